jzjpcc_memory_stage: RTL and testbench

Memory (MEM) stage of the jzjpcc RV32I pipeline. It sits directly downstream of execute and registers the execute outputs: ALU result, rd info, memory control and write data/byte mask. It runs a req/ack transaction on the data-memory port, extracts and sign-extends load data, and drives the writeback pipeline register. It stalls upstream while a memory transaction is outstanding and provides a forwarding path for the result held in the MEM register.

---
 rtl/jzjpcc_memory_pkg.sv | 35 +++
 rtl/jzjpcc_load_extract.sv | 29 ++
 rtl/jzjpcc_memory_stage.sv | 139 +++++++++++++
 tb/tb_jzjpcc_memory_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_memory_pkg.sv
// jzjpcc MEM-stage shared types: rd source, funct3 width codes,
// MEM-stage FSM states and the MEM pipeline register bundle.
package jzjpcc_memory_pkg;

  typedef enum logic [1:0] {
    RD_SRC_ALU = 2'b00,
    RD_SRC_MEM = 2'b01
  } rd_source_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // rd_src is kept raw so reserved codes 1x survive (treated as ALU)
  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [4:0]  rd_addr;
    logic [1:0]  rd_src;
    logic        rd_we;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_reg_t;

endpackage

// File: rtl/jzjpcc_load_extract.sv
// Load data extraction: picks byte/half/word from the read word by
// funct3 and addr[1:0]; ports rdata, funct3, byte_off in, result out.
module jzjpcc_load_extract
  import jzjpcc_memory_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rdata[8*byte_off +: 8];
    h      = byte_off[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'h0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'h0, h};
      F3_W:    result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/jzjpcc_memory_stage.sv
// jzjpcc MEM stage: registers execute outputs, runs the dmem req/ack
// handshake with timeout, extracts loads, forwards, drives WB register.
module jzjpcc_memory_stage
  import jzjpcc_memory_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_aluResult,
  input  logic [4:0]  ex_rdAddr,
  input  logic [1:0]  ex_rdSource,
  input  logic        ex_rdWriteEnable,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_memWriteData,
  input  logic [3:0]  ex_memByteMask,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byteMask,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rdAddr,
  output logic [31:0] fwd_rdData,
  output logic [4:0]  wb_rdAddr,
  output logic        wb_rdWriteEnable,
  output logic [31:0] wb_rdData,
  output logic        memFault
);

  localparam int unsigned CW =
    (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  mem_reg_t    mem_q, mem_d;
  logic [CW-1:0] wait_q, wait_d;
  logic        fault_q, fault_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;

  mem_state_t  state;
  logic        mem_op, misal, bad_op;
  logic        timeout, to_fault;
  logic [31:0] load_data;

  jzjpcc_load_extract u_extract (
    .rdata    (dmem_rdata),
    .funct3   (mem_q.funct3),
    .byte_off (mem_q.alu[1:0]),
    .result   (load_data)
  );

  always_comb begin
    mem_op  = mem_q.valid & (mem_q.mem_read | mem_q.mem_write);
    // half codes end in 01, word and reserved codes have bit 1 set
    misal   = ((mem_q.funct3[1:0] == 2'b01) & mem_q.alu[0])
            | (mem_q.funct3[1] & (mem_q.alu[1:0] != 2'b00));
    bad_op  = mem_op & misal;
    state   = (mem_op & !misal) ? ACCESS : IDLE;
    timeout = (MAX_WAIT != 0) && (wait_q == CW'(MAX_WAIT));
    // an ack in the expiry cycle still completes the access
    to_fault = (state == ACCESS) & timeout & !dmem_ack;
    stall    = (state == ACCESS) & !dmem_ack & !timeout;
  end

  assign dmem_req      = (state == ACCESS) & !timeout;
  assign dmem_we       = dmem_req & mem_q.mem_write;
  assign dmem_addr     = mem_q.alu[31:2];
  assign dmem_wdata    = mem_q.wdata;
  assign dmem_byteMask = mem_q.mem_write ? mem_q.mask : 4'hF;

  assign fwd_valid  = mem_q.valid & mem_q.rd_we
                    & (mem_q.rd_src != RD_SRC_MEM)
                    & (mem_q.rd_addr != 5'd0);
  assign fwd_rdAddr = mem_q.rd_addr;
  assign fwd_rdData = mem_q.alu;

  always_comb begin
    mem_d = mem_q;
    if (!stall) begin
      mem_d.valid     = ex_valid;
      mem_d.alu       = ex_aluResult;
      mem_d.rd_addr   = ex_rdAddr;
      mem_d.rd_src    = ex_rdSource;
      mem_d.rd_we     = ex_rdWriteEnable;
      mem_d.mem_read  = ex_memRead;
      mem_d.mem_write = ex_memWrite;
      mem_d.funct3    = ex_funct3;
      mem_d.wdata     = ex_memWriteData;
      mem_d.mask      = ex_memByteMask;
    end

    wait_d = '0;
    if ((MAX_WAIT != 0) && (state == ACCESS)
        && !dmem_ack && !timeout)
      wait_d = wait_q + CW'(1);

    fault_d = fault_q | bad_op | to_fault;

    wb_we_d = mem_q.valid & mem_q.rd_we
            & (mem_q.rd_addr != 5'd0)
            & !stall & !mem_q.mem_write
            & !bad_op & !to_fault;
    wb_addr_d = mem_q.rd_addr;
    wb_data_d = (mem_q.rd_src == RD_SRC_MEM) ? load_data
                                             : mem_q.alu;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q.valid <= 1'b0;
      wait_q      <= '0;
      fault_q     <= 1'b0;
      wb_we_q     <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      wb_we_q <= wb_we_d;
    end
  end

  always_ff @(posedge clock) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
  end

  assign wb_rdAddr        = wb_addr_q;
  assign wb_rdWriteEnable = wb_we_q;
  assign wb_rdData        = wb_data_q;
  assign memFault         = fault_q;

endmodule

// File: tb/tb_jzjpcc_memory_stage.sv
// Bench for jzjpcc_memory_stage: directed and random ops checked
// against a behavioural per-instruction model.
module tb_jzjpcc_memory_stage;

  localparam int MAXW = 4;

  logic        clock, reset;
  logic        ex_valid, ex_rdWriteEnable, ex_memRead, ex_memWrite;
  logic [31:0] ex_aluResult, ex_memWriteData;
  logic [4:0]  ex_rdAddr;
  logic [1:0]  ex_rdSource;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_memByteMask;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byteMask;
  logic        fwd_valid, wb_rdWriteEnable, memFault;
  logic [4:0]  fwd_rdAddr, wb_rdAddr;
  logic [31:0] fwd_rdData, wb_rdData;

  int n_cmp = 0;
  int n_bad = 0;
  bit fault_m = 0;

  jzjpcc_memory_stage #(.MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_aluResult(ex_aluResult),
    .ex_rdAddr(ex_rdAddr), .ex_rdSource(ex_rdSource),
    .ex_rdWriteEnable(ex_rdWriteEnable),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_funct3(ex_funct3), .ex_memWriteData(ex_memWriteData),
    .ex_memByteMask(ex_memByteMask),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_byteMask(dmem_byteMask), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .fwd_valid(fwd_valid), .fwd_rdAddr(fwd_rdAddr),
    .fwd_rdData(fwd_rdData),
    .wb_rdAddr(wb_rdAddr), .wb_rdWriteEnable(wb_rdWriteEnable),
    .wb_rdData(wb_rdData), .memFault(memFault)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext(logic [31:0] w,
                                      logic [2:0] f3,
                                      logic [1:0] off);
    logic [31:0] bv, hv;
    bv = (w >> (8 * off)) & 32'hFF;
    hv = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0: return (bv >= 128) ? bv - 32'd256 : bv;
      3'd4: return bv;
      3'd1: return (hv >= 32768) ? hv - 32'd65536 : hv;
      3'd5: return hv;
      default: return w;
    endcase
  endfunction

  task automatic bubble();
    ex_valid = 0; ex_memRead = 0; ex_memWrite = 0;
    ex_rdWriteEnable = 0;
  endtask

  task automatic do_op(bit we, logic [1:0] src, bit mr, bit mw,
                       logic [2:0] f3, logic [31:0] a,
                       logic [31:0] wd, logic [3:0] mk,
                       logic [4:0] rd, int dly, logic [31:0] rdat);
    bit memop, mis, acc, fin, timed, exp_we, fv;
    ex_valid = 1; ex_rdWriteEnable = we; ex_rdSource = src;
    ex_memRead = mr; ex_memWrite = mw; ex_funct3 = f3;
    ex_aluResult = a; ex_memWriteData = wd;
    ex_memByteMask = mk; ex_rdAddr = rd;
    @(posedge clock); #1;
    bubble();
    memop = mr || mw;
    mis = memop && (((f3[1:0] == 2'b01) && a[0] == 1'b1) ||
                    (f3[1] == 1'b1 && a[1:0] != 2'b00));
    acc = memop && !mis;
    fv = we && src != 2'd1 && rd != 0;
    chk("fwd_valid", 32'(fwd_valid), 32'(fv));
    if (fv) begin
      chk("fwd_rdData", fwd_rdData, a);
      chk("fwd_rdAddr", 32'(fwd_rdAddr), 32'(rd));
    end
    timed = 0;
    fin = 0;
    for (int c = 0; c < 16 && !fin; c++) begin
      dmem_ack = acc && c == dly;
      dmem_rdata = rdat;
      #1;
      chk("dmem_req", 32'(dmem_req), 32'(acc && c < MAXW));
      chk("stall", 32'(stall), 32'(acc && c < dly && c < MAXW));
      if (acc && c < MAXW) begin
        chk("dmem_addr", 32'(dmem_addr), a >> 2);
        chk("dmem_we", 32'(dmem_we), 32'(mw));
        chk("dmem_mask", 32'(dmem_byteMask),
            mw ? 32'(mk) : 32'hF);
        if (mw) chk("dmem_wdata", dmem_wdata, wd);
      end
      fin = !acc || c == dly || c == MAXW;
      timed = acc && c == MAXW && c != dly;
      @(posedge clock); #1;
      dmem_ack = 0;
    end
    fault_m = fault_m || mis || timed;
    exp_we = we && rd != 0 && !mw && !mis && !timed;
    chk("wb_we", 32'(wb_rdWriteEnable), 32'(exp_we));
    chk("memFault", 32'(memFault), 32'(fault_m));
    if (exp_we) begin
      chk("wb_rdAddr", 32'(wb_rdAddr), 32'(rd));
      chk("wb_rdData", wb_rdData,
          (src == 2'd1) ? ext(rdat, f3, a[1:0]) : a);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int k;
    reset = 1; dmem_ack = 0; dmem_rdata = 0;
    bubble();
    ex_aluResult = 0; ex_rdAddr = 0; ex_rdSource = 0;
    ex_funct3 = 0; ex_memWriteData = 0; ex_memByteMask = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wb_we", 32'(wb_rdWriteEnable), 0);
    chk("rst_fault", 32'(memFault), 0);
    chk("rst_fwd", 32'(fwd_valid), 0);

    do_op(1, 2'd0, 0, 0, 3'd0, 32'h12345678, 0, 0, 5'd5, 0, 0);
    do_op(1, 2'd1, 1, 0, 3'd0, 32'h103, 0, 0, 5'd6, 0,
          32'h80FF00AA);
    do_op(1, 2'd1, 1, 0, 3'd5, 32'h102, 0, 0, 5'd7, 3,
          32'hBEEF1234);
    do_op(0, 2'd0, 0, 1, 3'd2, 32'h200, 32'hCAFEF00D, 4'hF,
          5'd0, 1, 0);
    do_op(1, 2'd1, 1, 0, 3'd2, 32'h201, 0, 0, 5'd8, 0, 0);
    do_op(1, 2'd0, 0, 0, 3'd0, 32'h0BADC0DE, 0, 0, 5'd9, 0, 0);
    do_op(1, 2'd0, 0, 0, 3'd0, 32'h55, 0, 0, 5'd0, 0, 0);
    do_op(1, 2'd1, 1, 0, 3'd2, 32'h300, 0, 0, 5'd10, 99, 0);
    do_op(1, 2'd1, 1, 0, 3'd1, 32'h306, 0, 0, 5'd11, MAXW,
          32'h8001_7FFF);

    // reset while a load waits, then a stray ack
    ex_valid = 1; ex_rdWriteEnable = 1; ex_rdSource = 2'd1;
    ex_memRead = 1; ex_funct3 = 3'd2; ex_aluResult = 32'h400;
    ex_rdAddr = 5'd12;
    @(posedge clock); #1;
    bubble();
    chk("ra_req0", 32'(dmem_req), 1);
    @(posedge clock); #1;
    chk("ra_stall1", 32'(stall), 1);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    fault_m = 0;
    chk("ra_req", 32'(dmem_req), 0);
    chk("ra_stall", 32'(stall), 0);
    chk("ra_wb_we", 32'(wb_rdWriteEnable), 0);
    chk("ra_fault", 32'(memFault), 0);
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("ra_ack_req", 32'(dmem_req), 0);
    chk("ra_ack_stall", 32'(stall), 0);
    @(posedge clock); #1;
    dmem_ack = 0;
    chk("ra_ack_wb_we", 32'(wb_rdWriteEnable), 0);
    chk("ra_ack_fault", 32'(memFault), 0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 2);
      a = $urandom;
      if (k == 0) begin
        do_op(1'($urandom), ($urandom_range(0, 2) == 0) ? 2'd0 :
              2'($urandom_range(2, 3)), 0, 0, 3'($urandom),
              a, 0, 0, 5'($urandom), 0, 0);
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        if (k == 2) f3 = {1'b0, f3[1:0]};
        if ($urandom_range(0, 7) != 0) begin
          if (f3[1]) a[1:0] = 2'b00;
          else if (f3[0]) a[0] = 1'b0;
        end
        if (k == 1)
          do_op(1'($urandom), 2'd1, 1, 0, f3, a, 0, 0,
                5'($urandom), $urandom_range(0, 5), $urandom);
        else
          do_op(1'($urandom), 2'd0, 0, 1, f3, a, $urandom,
                4'($urandom), 5'($urandom),
                $urandom_range(0, 5), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
